// File: rtl/pmem_arbiter_if.sv
// pmem_arbiter_if: IFU/LSU request/response channels plus the Pmem port.
// slave = arbiter side; master = requesters and the Pmem model.
interface pmem_arbiter_if;
   logic        ifu_req_valid;
   logic        ifu_req_ready;
   logic [63:0] ifu_req_addr;
   logic        ifu_resp_valid;
   logic        ifu_resp_ready;
   logic [63:0] ifu_resp_data;
   logic        lsu_req_valid;
   logic        lsu_req_ready;
   logic [63:0] lsu_req_addr;
   logic        lsu_req_wen;
   logic [63:0] lsu_req_wdata;
   logic [7:0]  lsu_req_wmask;
   logic        lsu_resp_valid;
   logic        lsu_resp_ready;
   logic [63:0] lsu_resp_data;
   logic [63:0] pmem_raddr;
   logic        pmem_rvalid;
   logic [63:0] pmem_rdata;
   logic [63:0] pmem_waddr;
   logic [63:0] pmem_wdata;
   logic [7:0]  pmem_wmask;

   modport slave (
      input  ifu_req_valid, ifu_req_addr, ifu_resp_ready,
      input  lsu_req_valid, lsu_req_addr, lsu_req_wen,
      input  lsu_req_wdata, lsu_req_wmask, lsu_resp_ready,
      input  pmem_rdata,
      output ifu_req_ready, ifu_resp_valid, ifu_resp_data,
      output lsu_req_ready, lsu_resp_valid, lsu_resp_data,
      output pmem_raddr, pmem_rvalid, pmem_waddr,
      output pmem_wdata, pmem_wmask
   );

   modport master (
      output ifu_req_valid, ifu_req_addr, ifu_resp_ready,
      output lsu_req_valid, lsu_req_addr, lsu_req_wen,
      output lsu_req_wdata, lsu_req_wmask, lsu_resp_ready,
      output pmem_rdata,
      input  ifu_req_ready, ifu_resp_valid, ifu_resp_data,
      input  lsu_req_ready, lsu_resp_valid, lsu_resp_data,
      input  pmem_raddr, pmem_rvalid, pmem_waddr,
      input  pmem_wdata, pmem_wmask
   );
endinterface

// File: rtl/pmem_arbiter.sv
// pmem_arbiter: round-robin IFU/LSU share of the single Pmem port.
// Optional PMEM_ARB_PERF_EN adds grant and conflict-cycle counters.
module pmem_arbiter #(
   parameter int unsigned MEM_LATENCY = 2
) (
   input  logic          clock,
   input  logic          reset_n,
   pmem_arbiter_if.slave bus
`ifdef PMEM_ARB_PERF_EN
   ,
   output logic [31:0]   perf_ifu_grants,
   output logic [31:0]   perf_lsu_grants,
   output logic [31:0]   perf_conflict_cycles
`endif
);

   typedef enum logic [1:0] {
      S_IDLE, S_WAIT, S_ACCESS, S_RESP
   } state_t;

   localparam logic [3:0] CNT_LOAD =
      (MEM_LATENCY == 0) ? 4'd0 : 4'(MEM_LATENCY - 1);

   state_t      state;
   state_t      state_nx;
   logic [3:0]  cnt;
   logic        owner_lsu;
   logic        last_lsu;
   logic        wen_q;
   logic [7:0]  wmask_q;
   logic [63:0] addr_q;
   logic [63:0] wdata_q;
   logic [63:0] resp_q;
   logic        grant_ifu;
   logic        grant_lsu;
   logic        accept;
   logic        resp_fire;

   // Round-robin: a lone requester wins, a tie goes to the one not served last.
   always_comb begin
      grant_ifu = bus.ifu_req_valid & (~bus.lsu_req_valid | last_lsu);
      grant_lsu = bus.lsu_req_valid & (~bus.ifu_req_valid | ~last_lsu);
      accept    = (state == S_IDLE) & (grant_ifu | grant_lsu);
      resp_fire = (state == S_RESP) &
                  (owner_lsu ? bus.lsu_resp_ready : bus.ifu_resp_ready);
   end

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nx;
   end

   // Next-state: accept, optional wait, one access cycle, hold response.
   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:
            if (accept)
               state_nx = (MEM_LATENCY == 0) ? S_ACCESS : S_WAIT;
         S_WAIT:
            if (cnt == 4'd0) state_nx = S_ACCESS;
         S_ACCESS:
            state_nx = S_RESP;
         S_RESP:
            if (resp_fire) state_nx = S_IDLE;
         default:
            state_nx = S_IDLE;
      endcase
   end

   // Outputs: Pmem strobes only in ACCESS, responses only in RESP.
   always_comb begin
      bus.ifu_req_ready  = 1'b0;
      bus.lsu_req_ready  = 1'b0;
      bus.ifu_resp_valid = 1'b0;
      bus.lsu_resp_valid = 1'b0;
      bus.ifu_resp_data  = '0;
      bus.lsu_resp_data  = '0;
      bus.pmem_rvalid    = 1'b0;
      bus.pmem_wmask     = '0;
      unique case (state)
         S_IDLE: begin
            bus.ifu_req_ready = reset_n & grant_ifu;
            bus.lsu_req_ready = reset_n & grant_lsu;
         end
         S_ACCESS: begin
            bus.pmem_rvalid = ~wen_q;
            bus.pmem_wmask  = wen_q ? wmask_q : 8'h00;
         end
         S_RESP: begin
            bus.ifu_resp_valid = ~owner_lsu;
            bus.lsu_resp_valid = owner_lsu;
            bus.ifu_resp_data  = owner_lsu ? 64'd0 : resp_q;
            bus.lsu_resp_data  = owner_lsu ? resp_q : 64'd0;
         end
         default: ;
      endcase
   end

   assign bus.pmem_raddr = addr_q;
   assign bus.pmem_waddr = addr_q;
   assign bus.pmem_wdata = wdata_q;

   // Latch the winning request, run the wait counter, capture read data.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt       <= 4'd0;
         owner_lsu <= 1'b0;
         last_lsu  <= 1'b1;
         wen_q     <= 1'b0;
         wmask_q   <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         resp_q    <= '0;
      end else begin
         if (accept) begin
            cnt       <= CNT_LOAD;
            owner_lsu <= grant_lsu;
            last_lsu  <= grant_lsu;
            wen_q     <= grant_lsu & bus.lsu_req_wen;
            wmask_q   <= grant_lsu ? bus.lsu_req_wmask : 8'h00;
            addr_q    <= grant_lsu ? bus.lsu_req_addr : bus.ifu_req_addr;
            wdata_q   <= grant_lsu ? bus.lsu_req_wdata : 64'd0;
         end else if (state == S_WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
         if (state == S_ACCESS)
            resp_q <= wen_q ? 64'd0 : bus.pmem_rdata;
      end
   end

`ifdef PMEM_ARB_PERF_EN
   // Accept counts per requester and cycles where a valid request is stalled.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         perf_ifu_grants      <= '0;
         perf_lsu_grants      <= '0;
         perf_conflict_cycles <= '0;
      end else begin
         if (accept & grant_ifu)
            perf_ifu_grants <= perf_ifu_grants + 32'd1;
         if (accept & grant_lsu)
            perf_lsu_grants <= perf_lsu_grants + 32'd1;
         if ((bus.ifu_req_valid & ~bus.ifu_req_ready) |
             (bus.lsu_req_valid & ~bus.lsu_req_ready))
            perf_conflict_cycles <= perf_conflict_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pmem_arbiter.sv
// tb_pmem_arbiter: directed checks of pmem_arbiter with MEM_LATENCY=2.
// Perf-counter checks are compiled only with PMEM_ARB_PERF_EN.
module tb_pmem_arbiter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_pass = 0;
   int   n_fail = 0;

   pmem_arbiter_if bus ();

`ifdef PMEM_ARB_PERF_EN
   logic [31:0] perf_ifu;
   logic [31:0] perf_lsu;
   logic [31:0] perf_cfl;
`endif

   pmem_arbiter #(.MEM_LATENCY(2)) dut (
      .clock   (clk),
      .reset_n (rst_n),
      .bus     (bus)
`ifdef PMEM_ARB_PERF_EN
      ,
      .perf_ifu_grants      (perf_ifu),
      .perf_lsu_grants      (perf_lsu),
      .perf_conflict_cycles (perf_cfl)
`endif
   );

   always #5 clk = ~clk;

   // Pmem model: one known word, every other address reads back inverted.
   assign bus.pmem_rdata = (bus.pmem_raddr == 64'h8000_0000) ?
                           64'h0000_0013_0000_0297 : ~bus.pmem_raddr;

   int         rv_cnt = 0;
   int         wm_cnt = 0;
   int         wm_evt = 0;
   logic [7:0] wm_last = 8'h00;

   // Count Pmem read strobes and write-mask cycles at each clock edge.
   always @(posedge clk) begin
      if (bus.pmem_rvalid) rv_cnt++;
      if (bus.pmem_wmask != 8'h00) begin
         wm_cnt++;
         wm_last = bus.pmem_wmask;
      end
   end

   // Catch any nonzero write mask, even a glitch between edges.
   always @(bus.pmem_wmask) begin
      if (bus.pmem_wmask != 8'h00) wm_evt++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: sim time expired, got no finish expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic txn(input bit lsu, input logic [63:0] addr,
                      input bit wen, input logic [63:0] wd,
                      input logic [7:0] wm, output int lat,
                      output logic [63:0] data);
      @(negedge clk);
      if (lsu) begin
         bus.lsu_req_valid = 1'b1;
         bus.lsu_req_addr  = addr;
         bus.lsu_req_wen   = wen;
         bus.lsu_req_wdata = wd;
         bus.lsu_req_wmask = wm;
      end else begin
         bus.ifu_req_valid = 1'b1;
         bus.ifu_req_addr  = addr;
      end
      #1;
      chk("req_ready", lsu ? bus.lsu_req_ready : bus.ifu_req_ready, 64'd1);
      @(negedge clk);
      bus.ifu_req_valid = 1'b0;
      bus.lsu_req_valid = 1'b0;
      lat = 1;
      #1;
      while (!(lsu ? bus.lsu_resp_valid : bus.ifu_resp_valid) && lat < 20) begin
         @(negedge clk);
         #1;
         lat++;
      end
      data = lsu ? bus.lsu_resp_data : bus.ifu_resp_data;
      if (lsu) bus.lsu_resp_ready = 1'b1;
      else     bus.ifu_resp_ready = 1'b1;
      @(negedge clk);
      bus.ifu_resp_ready = 1'b0;
      bus.lsu_resp_ready = 1'b0;
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_ifu_rdy"},  bus.ifu_req_ready,  64'd0);
      chk({tag, "_lsu_rdy"},  bus.lsu_req_ready,  64'd0);
      chk({tag, "_ifu_rv"},   bus.ifu_resp_valid, 64'd0);
      chk({tag, "_lsu_rv"},   bus.lsu_resp_valid, 64'd0);
      chk({tag, "_ifu_rd"},   bus.ifu_resp_data,  64'd0);
      chk({tag, "_lsu_rd"},   bus.lsu_resp_data,  64'd0);
      chk({tag, "_rvalid"},   bus.pmem_rvalid,    64'd0);
      chk({tag, "_wmask"},    bus.pmem_wmask,     64'd0);
      chk({tag, "_raddr"},    bus.pmem_raddr,     64'd0);
      chk({tag, "_waddr"},    bus.pmem_waddr,     64'd0);
      chk({tag, "_wdata"},    bus.pmem_wdata,     64'd0);
   endtask

   int          lat;
   logic [63:0] data;
   int          base0;
   int          base1;
   int          base2;
   int          ng;
   bit          both_rdy;
   bit          g [4];

   initial begin
      bus.ifu_req_valid  = 1'b0;
      bus.ifu_req_addr   = '0;
      bus.ifu_resp_ready = 1'b0;
      bus.lsu_req_valid  = 1'b0;
      bus.lsu_req_addr   = '0;
      bus.lsu_req_wen    = 1'b0;
      bus.lsu_req_wdata  = '0;
      bus.lsu_req_wmask  = '0;
      bus.lsu_resp_ready = 1'b0;

      // Reset state, requester valid must not see ready.
      @(negedge clk);
      bus.ifu_req_valid = 1'b1;
      #1;
      chk_outputs_zero("rst");
      @(negedge clk);
      bus.ifu_req_valid = 1'b0;
      rst_n = 1'b1;

      // 1: IFU read with latency 2.
      base0 = rv_cnt;
      txn(1'b0, 64'h8000_0000, 1'b0, 64'd0, 8'h00, lat, data);
      chk("t1_lat", 64'(lat), 64'd4);
      chk("t1_data", data, 64'h0000_0013_0000_0297);
      chk("t1_rvalid_cycles", 64'(rv_cnt - base0), 64'd1);
      chk("t1_raddr", bus.pmem_raddr, 64'h8000_0000);

      // 2: LSU write, mask only in the access cycle.
      base0 = wm_cnt;
      base1 = wm_evt;
      base2 = rv_cnt;
      txn(1'b1, 64'h8000_1000, 1'b1, 64'hDEAD_BEEF, 8'h0F, lat, data);
      chk("t2_lat", 64'(lat), 64'd4);
      chk("t2_ack_data", data, 64'd0);
      chk("t2_wmask_cycles", 64'(wm_cnt - base0), 64'd1);
      chk("t2_wmask_events", 64'(wm_evt - base1), 64'd1);
      chk("t2_wmask_val", wm_last, 64'h0F);
      chk("t2_no_read", 64'(rv_cnt - base2), 64'd0);
      chk("t2_waddr", bus.pmem_waddr, 64'h8000_1000);
      chk("t2_wdata", bus.pmem_wdata, 64'hDEAD_BEEF);
      chk("t2_wmask_idle", bus.pmem_wmask, 64'd0);

      // 3: both valid from the first cycle after reset.
      @(negedge clk);
      rst_n = 1'b0;
      bus.ifu_req_valid  = 1'b1;
      bus.ifu_req_addr   = 64'h100;
      bus.lsu_req_valid  = 1'b1;
      bus.lsu_req_addr   = 64'h200;
      bus.lsu_req_wen    = 1'b0;
      bus.ifu_resp_ready = 1'b1;
      bus.lsu_resp_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      ng = 0;
      both_rdy = 1'b0;
      for (int c = 0; c < 40 && ng < 4; c++) begin
         #1;
         if (bus.ifu_req_ready && bus.lsu_req_ready) both_rdy = 1'b1;
         if (bus.ifu_req_ready) begin
            g[ng] = 1'b0;
            ng++;
         end else if (bus.lsu_req_ready) begin
            g[ng] = 1'b1;
            ng++;
         end
         @(negedge clk);
      end
      bus.ifu_req_valid = 1'b0;
      bus.lsu_req_valid = 1'b0;
      chk("t3_grants", 64'(ng), 64'd4);
      chk("t3_g0_ifu", 64'(g[0]), 64'd0);
      chk("t3_g1_lsu", 64'(g[1]), 64'd1);
      chk("t3_g2_ifu", 64'(g[2]), 64'd0);
      chk("t3_g3_lsu", 64'(g[3]), 64'd1);
      chk("t3_both_ready", 64'(both_rdy), 64'd0);
      repeat (8) @(negedge clk);
      bus.ifu_resp_ready = 1'b0;
      bus.lsu_resp_ready = 1'b0;
      @(negedge clk);

      // 4: response held while IFU stalls five cycles.
      bus.ifu_req_valid = 1'b1;
      bus.ifu_req_addr  = 64'h8000_0040;
      #1;
      chk("t4_accept", bus.ifu_req_ready, 64'd1);
      @(negedge clk);
      bus.ifu_req_addr  = 64'h8000_0080;
      bus.lsu_req_valid = 1'b1;
      bus.lsu_req_addr  = 64'h8000_00C0;
      lat = 1;
      #1;
      while (!bus.ifu_resp_valid && lat < 20) begin
         @(negedge clk);
         #1;
         lat++;
      end
      chk("t4_lat", 64'(lat), 64'd4);
      for (int k = 0; k < 5; k++) begin
         chk("t4_resp_valid", bus.ifu_resp_valid, 64'd1);
         chk("t4_resp_data", bus.ifu_resp_data, ~64'h8000_0040);
         chk("t4_ifu_ready", bus.ifu_req_ready, 64'd0);
         chk("t4_lsu_ready", bus.lsu_req_ready, 64'd0);
         chk("t4_rvalid", bus.pmem_rvalid, 64'd0);
         @(negedge clk);
         #1;
      end
      bus.ifu_resp_ready = 1'b1;
      bus.ifu_req_valid  = 1'b0;
      bus.lsu_req_valid  = 1'b0;
      @(negedge clk);
      bus.ifu_resp_ready = 1'b0;
      #1;
      chk("t4_resp_done", bus.ifu_resp_valid, 64'd0);

      // 5: reset during the wait of an LSU write.
      base0 = wm_evt;
      @(negedge clk);
      bus.lsu_req_valid = 1'b1;
      bus.lsu_req_addr  = 64'h8000_2000;
      bus.lsu_req_wen   = 1'b1;
      bus.lsu_req_wdata = 64'h1234_5678;
      bus.lsu_req_wmask = 8'hFF;
      #1;
      chk("t5_accept", bus.lsu_req_ready, 64'd1);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk_outputs_zero("t5_rst");
      repeat (3) @(negedge clk);
      bus.lsu_req_valid = 1'b0;
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      chk("t5_no_lsu_resp", bus.lsu_resp_valid, 64'd0);
      chk("t5_wmask_never", 64'(wm_evt - base0), 64'd0);
      txn(1'b0, 64'h8000_0000, 1'b0, 64'd0, 8'h00, lat, data);
      chk("t5_lat", 64'(lat), 64'd4);
      chk("t5_data", data, 64'h0000_0013_0000_0297);

`ifdef PMEM_ARB_PERF_EN
      // 6: three IFU reads with one stalled LSU cycle.
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      bus.ifu_req_valid = 1'b1;
      bus.ifu_req_addr  = 64'h8000_0000;
      @(negedge clk);
      bus.ifu_req_valid = 1'b0;
      bus.lsu_req_valid = 1'b1;
      bus.lsu_req_wen   = 1'b0;
      @(negedge clk);
      bus.lsu_req_valid  = 1'b0;
      bus.ifu_resp_ready = 1'b1;
      repeat (4) @(negedge clk);
      bus.ifu_resp_ready = 1'b0;
      txn(1'b0, 64'h8000_0008, 1'b0, 64'd0, 8'h00, lat, data);
      txn(1'b0, 64'h8000_0010, 1'b0, 64'd0, 8'h00, lat, data);
      #1;
      chk("t6_ifu_grants", 64'(perf_ifu), 64'd3);
      chk("t6_lsu_grants", 64'(perf_lsu), 64'd0);
      chk("t6_conflicts", 64'(perf_cfl), 64'd1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
